// File: rtl/ddr3_port_arbiter.sv
// Two-port arbiter in front of the DDR3 Avalon-MM master: scanout reads
// (priority, urgent preempt, outstanding throttle) versus rasterizer writes.
module ddr3_port_arbiter #(
  parameter logic [7:0] MAX_HOLD        = 8'd16,
  parameter logic [7:0] MAX_OUTSTANDING = 8'd32
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic [28:0] rd_address,
  input  logic        rd_read,
  input  logic        rd_urgent,
  output logic        rd_waitrequest,
  output logic [63:0] rd_readdata,
  output logic        rd_readdatavalid,

  input  logic [28:0] wr_address,
  input  logic        wr_write,
  input  logic [63:0] wr_writedata,
  input  logic [7:0]  wr_byteenable,
  output logic        wr_waitrequest,

  output logic [28:0] m_address,
  output logic [7:0]  m_burstcount,
  output logic        m_read,
  output logic        m_write,
  output logic [63:0] m_writedata,
  output logic [7:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [63:0] m_readdata,
  input  logic        m_readdatavalid,

  output logic [1:0]  grant,
  output logic [7:0]  rd_outstanding
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_R = 2'b01,
    GRANT_W = 2'b10
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] hold_cnt;

  logic sel_r;
  logic sel_w;
  logic rd_full;
  logic acc_r;
  logic acc_w;
  logic hold_last;
  logic rsp;

  assign sel_r     = (state == GRANT_R);
  assign sel_w     = (state == GRANT_W);
  assign rd_full   = (rd_outstanding >= MAX_OUTSTANDING);
  assign hold_last = (hold_cnt == MAX_HOLD - 8'd1);

  assign m_read  = sel_r && rd_read && !rd_full;
  assign m_write = sel_w && wr_write;
  assign acc_r   = m_read && !m_waitrequest;
  assign acc_w   = m_write && !m_waitrequest;

  assign m_address    = sel_w ? wr_address : rd_address;
  assign m_burstcount = 8'h01;
  assign m_writedata  = wr_writedata;
  assign m_byteenable = sel_w ? wr_byteenable : 8'hFF;

  assign rd_waitrequest = !sel_r || rd_full || m_waitrequest;
  assign wr_waitrequest = !sel_w || m_waitrequest;

  assign rd_readdata      = m_readdata;
  assign rd_readdatavalid = m_readdatavalid;

  assign grant = state;

  // Stray responses with nothing in flight must not wrap the counter.
  assign rsp = m_readdatavalid && (rd_outstanding != 8'd0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rd_read)
          state_nxt = GRANT_R;
        else if (wr_write)
          state_nxt = GRANT_W;
      end
      GRANT_R: begin
        if (!rd_read)
          state_nxt = wr_write ? GRANT_W : IDLE;
        else if (rd_full && wr_write)
          state_nxt = GRANT_W;
        else if (acc_r && hold_last && wr_write)
          state_nxt = GRANT_W;
      end
      GRANT_W: begin
        if (!wr_write)
          state_nxt = rd_read ? GRANT_R : IDLE;
        else if (acc_w && rd_read && (rd_urgent || hold_last))
          state_nxt = GRANT_R;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Saturates at the yield point so a long solo grant keeps yielding
  // on the very next accept once a peer shows up.
  always_ff @(posedge clock) begin
    if (!reset_n)
      hold_cnt <= 8'd0;
    else if (state_nxt != state)
      hold_cnt <= 8'd0;
    else if ((acc_r || acc_w) && !hold_last)
      hold_cnt <= hold_cnt + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      rd_outstanding <= 8'd0;
    else begin
      unique case ({acc_r, rsp})
        2'b10:   rd_outstanding <= rd_outstanding + 8'd1;
        2'b01:   rd_outstanding <= rd_outstanding - 8'd1;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: expected bus commands are queued
// by the stimulus and popped by a monitor on every accepted command.
module tb_ddr3_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [28:0] rd_address;
  logic        rd_read;
  logic        rd_urgent;
  logic        rd_waitrequest;
  logic [63:0] rd_readdata;
  logic        rd_readdatavalid;
  logic [28:0] wr_address;
  logic        wr_write;
  logic [63:0] wr_writedata;
  logic [7:0]  wr_byteenable;
  logic        wr_waitrequest;
  logic [28:0] m_address;
  logic [7:0]  m_burstcount;
  logic        m_read;
  logic        m_write;
  logic [63:0] m_writedata;
  logic [7:0]  m_byteenable;
  logic        m_waitrequest;
  logic [63:0] m_readdata;
  logic        m_readdatavalid;
  logic [1:0]  grant;
  logic [7:0]  rd_outstanding;

  int total = 0;
  int bad   = 0;
  int rd_cnt, wr_cnt, rd_limit, wr_limit;

  typedef struct {
    logic        w;
    logic [28:0] a;
    logic [63:0] d;
    logic [7:0]  be;
    logic [1:0]  g;
  } exp_t;
  exp_t sb[$];

  ddr3_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .rd_address(rd_address), .rd_read(rd_read),
    .rd_urgent(rd_urgent), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata),
    .rd_readdatavalid(rd_readdatavalid),
    .wr_address(wr_address), .wr_write(wr_write),
    .wr_writedata(wr_writedata),
    .wr_byteenable(wr_byteenable),
    .wr_waitrequest(wr_waitrequest),
    .m_address(m_address), .m_burstcount(m_burstcount),
    .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .grant(grant), .rd_outstanding(rd_outstanding)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] wdata(input logic [28:0] a);
    return {3'b101, a, 3'b010, ~a};
  endfunction

  function automatic logic [7:0] be_of(input logic [28:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [28:0] a);
    sb.push_back('{1'b0, a, 64'h0, 8'hFF, 2'b01});
  endtask

  task automatic push_w(input logic [28:0] a);
    sb.push_back('{1'b1, a, wdata(a), be_of(a), 2'b10});
  endtask

  task automatic set_w(input logic [28:0] a);
    wr_address    = a;
    wr_writedata  = wdata(a);
    wr_byteenable = be_of(a);
  endtask

  // One clock: sample handshakes mid-cycle, then advance each
  // requester past any command accepted at the edge.
  task automatic tick();
    logic ar, aw;
    @(negedge clock);
    ar = reset_n && rd_read && !rd_waitrequest;
    aw = reset_n && wr_write && !wr_waitrequest;
    @(posedge clock);
    #1;
    if (ar) begin
      rd_cnt++;
      rd_address = rd_address + 29'd1;
      if (rd_cnt == rd_limit) rd_read = 1'b0;
    end
    if (aw) begin
      wr_cnt++;
      set_w(wr_address + 29'd1);
      if (wr_cnt == wr_limit) wr_write = 1'b0;
    end
  endtask

  task automatic run_to(input int rn, input int wn);
    int b;
    b = 0;
    while (!(rd_cnt >= rn && wr_cnt >= wn) && b < 300) begin
      tick();
      b++;
    end
    check("run_budget", 64'(b < 300), 64'd1);
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    rd_read         = 1'b0;
    rd_urgent       = 1'b0;
    wr_write        = 1'b0;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    tick();
    tick();
    reset_n  = 1'b1;
    rd_cnt   = 0;
    wr_cnt   = 0;
    rd_limit = 1000;
    wr_limit = 1000;
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (reset_n === 1'b1 && (m_read || m_write) && !m_waitrequest) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got addr %0h want none",
                 m_address);
      end else begin
        e = sb.pop_front();
        check("cmd_is_write", 64'(m_write), 64'(e.w));
        check("cmd_excl", 64'(m_read & m_write), 64'd0);
        check("cmd_addr", 64'(m_address), 64'(e.a));
        check("cmd_be", 64'(m_byteenable), 64'(e.be));
        check("cmd_grant", 64'(grant), 64'(e.g));
        check("cmd_burst", 64'(m_burstcount), 64'h1);
        if (e.w) check("cmd_wdata", m_writedata, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rd_address = 29'h0;
    m_readdata = 64'h0;
    set_w(29'h0);
    do_reset();

    // reset state
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_m_read", 64'(m_read), 64'd0);
    check("rst_m_write", 64'(m_write), 64'd0);
    check("rst_rd_wait", 64'(rd_waitrequest), 64'd1);
    check("rst_wr_wait", 64'(wr_waitrequest), 64'd1);
    check("rst_outst", 64'(rd_outstanding), 64'd0);

    // stray response: forwarded, not counted
    m_readdata      = 64'hFEED_0000_BEEF_0001;
    m_readdatavalid = 1'b1;
    #1;
    check("stray_valid", 64'(rd_readdatavalid), 64'd1);
    check("stray_data", rd_readdata, 64'hFEED_0000_BEEF_0001);
    tick();
    m_readdatavalid = 1'b0;
    check("stray_outst", 64'(rd_outstanding), 64'd0);

    // 40 back-to-back writes
    for (int i = 0; i < 40; i++) push_w(29'h100 + 29'(i));
    set_w(29'h100);
    wr_limit = 40;
    wr_write = 1'b1;
    for (int i = 0; i < 41; i++) begin
      tick();
      check("w_only_grant", 64'(grant), 64'h2);
    end
    check("w_only_count", 64'(wr_cnt), 64'd40);
    tick();
    check("w_only_idle", 64'(grant), 64'd0);

    // simultaneous requests, hold limit
    do_reset();
    for (int i = 0; i < 16; i++) push_r(29'h200 + 29'(i));
    for (int i = 0; i < 4; i++) push_w(29'h300 + 29'(i));
    for (int i = 16; i < 20; i++) push_r(29'h200 + 29'(i));
    rd_address = 29'h200;
    set_w(29'h300);
    rd_limit = 20;
    wr_limit = 4;
    rd_read  = 1'b1;
    wr_write = 1'b1;
    tick();
    check("tie_grant_r", 64'(grant), 64'h1);
    run_to(16, 0);
    check("hold_rd_cnt", 64'(rd_cnt), 64'd16);
    check("hold_grant_w", 64'(grant), 64'h2);
    run_to(20, 4);
    check("hold_outst", 64'(rd_outstanding), 64'd20);

    // urgent preempt with a stalled write
    do_reset();
    for (int i = 0; i < 3; i++) push_w(29'h400 + 29'(i));
    push_r(29'h500);
    push_r(29'h501);
    for (int i = 3; i < 8; i++) push_w(29'h400 + 29'(i));
    set_w(29'h400);
    wr_limit = 8;
    wr_write = 1'b1;
    run_to(0, 2);
    m_waitrequest = 1'b1;
    rd_address    = 29'h500;
    rd_limit      = 2;
    rd_read       = 1'b1;
    rd_urgent     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("urg_stall_wr", 64'(m_write), 64'd1);
      check("urg_stall_addr", 64'(m_address), 64'h402);
      check("urg_stall_grant", 64'(grant), 64'h2);
    end
    m_waitrequest = 1'b0;
    tick();
    check("urg_wr_done", 64'(wr_cnt), 64'd3);
    check("urg_grant_r", 64'(grant), 64'h1);
    tick();
    check("urg_first_rd", 64'(rd_cnt), 64'd1);
    rd_urgent = 1'b0;
    run_to(2, 8);

    // outstanding throttle
    do_reset();
    for (int i = 0; i < 33; i++) push_r(29'h600 + 29'(i));
    push_w(29'h700);
    rd_address = 29'h600;
    rd_read    = 1'b1;
    repeat (40) tick();
    #1;
    check("thr_rd_cnt", 64'(rd_cnt), 64'd32);
    check("thr_m_read", 64'(m_read), 64'd0);
    check("thr_rd_wait", 64'(rd_waitrequest), 64'd1);
    check("thr_outst", 64'(rd_outstanding), 64'd32);
    check("thr_grant", 64'(grant), 64'h1);
    m_readdata      = 64'h0123_4567_89AB_CDEF;
    m_readdatavalid = 1'b1;
    #1;
    check("rsp_valid", 64'(rd_readdatavalid), 64'd1);
    check("rsp_data", rd_readdata, 64'h0123_4567_89AB_CDEF);
    tick();
    m_readdatavalid = 1'b0;
    check("rsp_outst", 64'(rd_outstanding), 64'd31);
    repeat (5) tick();
    check("thr_rd_cnt2", 64'(rd_cnt), 64'd33);
    check("thr_outst2", 64'(rd_outstanding), 64'd32);
    set_w(29'h700);
    wr_limit = 1;
    wr_write = 1'b1;
    tick();
    check("thr_grant_w", 64'(grant), 64'h2);
    tick();
    check("thr_wr_cnt", 64'(wr_cnt), 64'd1);
    rd_read = 1'b0;
    tick();

    // read stalled 5 cycles while a write waits
    do_reset();
    for (int i = 0; i < 4; i++) push_r(29'h800 + 29'(i));
    push_w(29'h900);
    rd_address = 29'h800;
    rd_limit   = 4;
    rd_read    = 1'b1;
    run_to(1, 0);
    m_waitrequest = 1'b1;
    set_w(29'h900);
    wr_limit = 1;
    wr_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("stall_m_read", 64'(m_read), 64'd1);
      check("stall_addr", 64'(m_address), 64'h801);
      check("stall_grant", 64'(grant), 64'h1);
    end
    m_waitrequest = 1'b0;
    run_to(4, 1);

    // reset mid-burst
    do_reset();
    for (int i = 0; i < 3; i++) push_r(29'hA00 + 29'(i));
    rd_address = 29'hA00;
    set_w(29'hB00);
    rd_read  = 1'b1;
    wr_write = 1'b1;
    run_to(3, 0);
    reset_n = 1'b0;
    tick();
    #1;
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_read", 64'(m_read), 64'd0);
    check("mid_rst_write", 64'(m_write), 64'd0);
    check("mid_rst_outst", 64'(rd_outstanding), 64'd0);
    rd_read  = 1'b0;
    wr_write = 1'b0;
    reset_n  = 1'b1;
    tick();
    tick();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
